// File: rtl/id_ex_pipe.sv
// ID->EX pipeline stage: 2-entry skid buffer (MAIN presented, SKID overflow) feeding the ALU.
// Optional EX/MEM and MEM/WB operand forwarding is enabled by defining FORWARDING_EN.
module id_ex_pipe #(
   parameter int DATA_W     = 32,
   parameter int ALU_OP_W   = 4,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ALU_OP_W-1:0]   in_alu_op,
   input  logic                  in_alu_src,
   input  logic                  in_reg_write,
   input  logic [REG_ADDR_W-1:0] in_rs,
   input  logic [REG_ADDR_W-1:0] in_rt,
   input  logic [REG_ADDR_W-1:0] in_rd,
   input  logic [DATA_W-1:0]     in_data1,
   input  logic [DATA_W-1:0]     in_data2,
   input  logic [DATA_W-1:0]     in_imm,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ALU_OP_W-1:0]   out_alu_op,
   output logic                  out_alu_src,
   output logic                  out_reg_write,
   output logic [REG_ADDR_W-1:0] out_rd,
   output logic [DATA_W-1:0]     out_data1,
   output logic [DATA_W-1:0]     out_data2,
   output logic [DATA_W-1:0]     out_imm,
   input  logic                  exm_reg_write,
   input  logic [REG_ADDR_W-1:0] exm_rd,
   input  logic [DATA_W-1:0]     exm_result,
   input  logic                  mwb_reg_write,
   input  logic [REG_ADDR_W-1:0] mwb_rd,
   input  logic [DATA_W-1:0]     mwb_result
);

   // state | meaning
   // EMPTY | no entry held, out_valid=0
   // BUSY  | MAIN held and presented, SKID free
   // FULL  | MAIN presented, SKID holds the next entry, in_ready=0
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [ALU_OP_W-1:0]   op;
      logic                  src;
      logic                  reg_write;
      logic [REG_ADDR_W-1:0] rs;
      logic [REG_ADDR_W-1:0] rt;
      logic [REG_ADDR_W-1:0] rd;
      logic [DATA_W-1:0]     data1;
      logic [DATA_W-1:0]     data2;
      logic [DATA_W-1:0]     imm;
   } entry_t;

   state_t state, state_nx;
   entry_t main_q, skid_q, in_entry;
   logic   in_ready_q;
   logic   in_fire, out_fire;
   logic   load_main, load_skid, main_from_skid;

   assign in_entry = '{op: in_alu_op, src: in_alu_src, reg_write: in_reg_write,
                       rs: in_rs, rt: in_rt, rd: in_rd,
                       data1: in_data1, data2: in_data2, imm: in_imm};

   assign in_ready  = in_ready_q;
   assign out_valid = (state != EMPTY);
   assign in_fire   = in_valid & in_ready_q;
   assign out_fire  = out_valid & out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state      <= state_nx;
         in_ready_q <= (state_nx != FULL);
      end
   end

   always_comb begin
      state_nx       = state;
      load_main      = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      if (flush) begin
         state_nx = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  state_nx  = BUSY;
                  load_main = 1'b1;
               end
            end
            BUSY: begin
               if (in_fire && out_fire) begin
                  load_main = 1'b1;
               end else if (in_fire) begin
                  state_nx  = FULL;
                  load_skid = 1'b1;
               end else if (out_fire) begin
                  state_nx = EMPTY;
               end
            end
            FULL: begin
               if (out_fire) begin
                  state_nx       = BUSY;
                  load_main      = 1'b1;
                  main_from_skid = 1'b1;
               end
            end
            default: state_nx = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main) main_q <= main_from_skid ? skid_q : in_entry;
         if (load_skid) skid_q <= in_entry;
      end
   end

   assign out_alu_op    = main_q.op;
   assign out_alu_src   = main_q.src;
   assign out_reg_write = main_q.reg_write;
   assign out_rd        = main_q.rd;
   assign out_imm       = main_q.imm;

`ifdef FORWARDING_EN
   // Evaluated on MAIN every cycle so a stalled entry keeps picking up newer results.
   function automatic logic [DATA_W-1:0] fwd(input logic [REG_ADDR_W-1:0] src,
                                             input logic [DATA_W-1:0]     stored,
                                             input logic                  exm_we,
                                             input logic [REG_ADDR_W-1:0] exm_a,
                                             input logic [DATA_W-1:0]     exm_d,
                                             input logic                  mwb_we,
                                             input logic [REG_ADDR_W-1:0] mwb_a,
                                             input logic [DATA_W-1:0]     mwb_d);
      if (src == '0)                      return stored;
      else if (exm_we && (exm_a == src)) return exm_d;
      else if (mwb_we && (mwb_a == src)) return mwb_d;
      else                               return stored;
   endfunction

   assign out_data1 = fwd(main_q.rs, main_q.data1, exm_reg_write, exm_rd, exm_result,
                          mwb_reg_write, mwb_rd, mwb_result);
   assign out_data2 = fwd(main_q.rt, main_q.data2, exm_reg_write, exm_rd, exm_result,
                          mwb_reg_write, mwb_rd, mwb_result);
`else
   logic unused_fwd;
   assign unused_fwd = ^{exm_reg_write, exm_rd, exm_result, mwb_reg_write, mwb_rd, mwb_result,
                         main_q.rs, main_q.rt};
   assign out_data1 = main_q.data1;
   assign out_data2 = main_q.data2;
`endif

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed self-checking bench for id_ex_pipe; forwarding expectations follow FORWARDING_EN.
module tb_id_ex_pipe;
   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic        in_ready, out_valid;
   logic [3:0]  in_alu_op, out_alu_op;
   logic        in_alu_src, in_reg_write, out_alu_src, out_reg_write;
   logic [4:0]  in_rs, in_rt, in_rd, out_rd;
   logic [31:0] in_data1, in_data2, in_imm, out_data1, out_data2, out_imm;
   logic        exm_reg_write, mwb_reg_write;
   logic [4:0]  exm_rd, mwb_rd;
   logic [31:0] exm_result, mwb_result;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   id_ex_pipe dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_alu_op(in_alu_op), .in_alu_src(in_alu_src), .in_reg_write(in_reg_write),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
      .in_data1(in_data1), .in_data2(in_data2), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_alu_op(out_alu_op), .out_alu_src(out_alu_src), .out_reg_write(out_reg_write),
      .out_rd(out_rd), .out_data1(out_data1), .out_data2(out_data2), .out_imm(out_imm),
      .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
      .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
      in_valid = 1'b1; in_alu_op = op; in_rs = rs; in_rt = rt;
      in_rd = 5'd9; in_data1 = d1; in_data2 = d2; in_imm = imm;
      in_alu_src = 1'b0; in_reg_write = 1'b1;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_alu_op = '0; in_alu_src = 1'b0; in_reg_write = 1'b0;
      in_rs = '0; in_rt = '0; in_rd = '0; in_data1 = '0; in_data2 = '0; in_imm = '0;
      exm_reg_write = 1'b0; exm_rd = '0; exm_result = '0;
      mwb_reg_write = 1'b0; mwb_rd = '0; mwb_result = '0;
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_data1",     out_data1,      32'd0);
      #1 rst = 1'b0;
      step(); step();
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_in_ready",  32'(in_ready),  32'd1);

      // single ADD with EX always ready
      out_ready = 1'b1;
      offer(4'b0010, 5'd0, 5'd0, 32'd5, 32'd7, 32'h10);
      step();
      in_valid = 1'b0;
      chk("add_valid", 32'(out_valid),  32'd1);
      chk("add_op",    32'(out_alu_op), 32'h2);
      chk("add_d1",    out_data1,       32'd5);
      chk("add_d2",    out_data2,       32'd7);
      chk("add_imm",   out_imm,         32'h10);
      chk("add_rd",    32'(out_rd),     32'd9);
      step();
      chk("add_drain", 32'(out_valid),  32'd0);

      // stall: A then B fill both entries
      out_ready = 1'b0;
      offer(4'b0000, 5'd0, 5'd0, 32'd1, 32'h11, 32'hA);
      step();
      chk("stA_valid",   32'(out_valid), 32'd1);
      chk("stA_inready", 32'(in_ready),  32'd1);
      offer(4'b0110, 5'd0, 5'd0, 32'd2, 32'h22, 32'hB);
      step();
      in_valid = 1'b0;
      chk("stB_inready", 32'(in_ready),   32'd0);
      chk("stB_hold_d1", out_data1,       32'd1);
      chk("stB_hold_op", 32'(out_alu_op), 32'h0);
      step();
      chk("st_hold_d1",  out_data1,       32'd1);
      chk("st_hold_imm", out_imm,         32'hA);
      out_ready = 1'b1;
      #1;
      chk("emitA_d1",    out_data1,       32'd1);
      step();
      chk("emitB_valid", 32'(out_valid),  32'd1);
      chk("emitB_d1",    out_data1,       32'd2);
      chk("emitB_op",    32'(out_alu_op), 32'h6);
      chk("emitB_d2",    out_data2,       32'h22);
      chk("emitB_inrdy", 32'(in_ready),   32'd1);
      step();
      chk("emit_empty",  32'(out_valid),  32'd0);

      // flush while FULL with a new instruction offered
      out_ready = 1'b0;
      offer(4'b0001, 5'd0, 5'd0, 32'h21, 32'h0, 32'h0);
      step();
      offer(4'b0001, 5'd0, 5'd0, 32'h22, 32'h0, 32'h0);
      step();
      chk("fl_full", 32'(in_ready), 32'd0);
      offer(4'b0001, 5'd0, 5'd0, 32'h23, 32'h0, 32'h0);
      flush = 1'b1;
      step();
      chk("fl_valid",   32'(out_valid), 32'd0);
      chk("fl_inready", 32'(in_ready),  32'd1);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step();
      chk("fl_none", 32'(out_valid), 32'd0);

      // forwarding on MAIN rs=3 / rt=4
      out_ready = 1'b0;
      offer(4'b0010, 5'd3, 5'd4, 32'd9, 32'h77, 32'h66);
      in_alu_src = 1'b1;
      step();
      in_valid = 1'b0;
      exm_reg_write = 1'b1; exm_rd = 5'd3; exm_result = 32'h44;
      mwb_reg_write = 1'b1; mwb_rd = 5'd3; mwb_result = 32'h55;
      #1;
`ifdef FORWARDING_EN
      chk("fwd_exm", out_data1, 32'h44);
`else
      chk("fwd_exm", out_data1, 32'd9);
`endif
      chk("fwd_d2_nomatch", out_data2, 32'h77);
      exm_reg_write = 1'b0;
      #1;
`ifdef FORWARDING_EN
      chk("fwd_mwb", out_data1, 32'h55);
`else
      chk("fwd_mwb", out_data1, 32'd9);
`endif
      mwb_rd = 5'd4; exm_reg_write = 1'b1; exm_rd = 5'd7;
      #1;
`ifdef FORWARDING_EN
      chk("fwd_d2_rt", out_data2, 32'h55);
`else
      chk("fwd_d2_rt", out_data2, 32'h77);
`endif
      chk("fwd_d1_none", out_data1, 32'd9);
      chk("fwd_imm",     out_imm,   32'h66);
      // replace MAIN with rs=0 entry via simultaneous in/out fire
      exm_reg_write = 1'b0; mwb_reg_write = 1'b0;
      out_ready = 1'b1;
      offer(4'b0010, 5'd0, 5'd0, 32'd9, 32'h78, 32'h0);
      step();
      in_valid = 1'b0; out_ready = 1'b0;
      exm_reg_write = 1'b1; exm_rd = 5'd0; exm_result = 32'h44;
      mwb_reg_write = 1'b1; mwb_rd = 5'd0; mwb_result = 32'h55;
      #1;
      chk("fwd_r0_valid", 32'(out_valid), 32'd1);
      chk("fwd_r0_d1",    out_data1,      32'd9);
      chk("fwd_r0_d2",    out_data2,      32'h78);

      // async reset mid-transfer drops the held entry
      #2 rst = 1'b1;
      #1;
      chk("rst2_valid",   32'(out_valid), 32'd0);
      chk("rst2_inready", 32'(in_ready),  32'd1);
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
endmodule
